// File: rtl/systolic_drain_ctrl_if.sv
// Result stream from the drain controller: one row of column psums per beat.
// The master side presents the row FIFO head; the slave side accepts it
// with out_ready.
interface systolic_drain_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 4
);
  logic [COLS*2*DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/systolic_drain_ctrl.sv
// Drain controller for the output-stationary PE array.
// In IDLE the accumulate request passes straight through to the array's
// register enable. On start it walks the array's psum chains down one row per
// push, capturing the bottom-row psums into a small row FIFO that feeds a
// valid/ready stream. When the FIFO is full and nothing is popped, the array is
// simply held (set_reg low), so no row is ever lost.
module systolic_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         acc_en,
  input  logic                         start,
  input  logic [COLS*2*DATA_WIDTH-1:0] psum_tail,
  output logic                         set_reg,
  output logic                         sel_mux,
  output logic                         busy,
  output logic                         done,
  systolic_drain_ctrl_if.master        stream
);

  localparam int ROW_W = COLS * 2 * DATA_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RCW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t           state_r;
  logic [RCW-1:0]   row_cnt_r;
  logic             busy_r;
  logic             done_r;

  logic [ROW_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [ROW_W-1:0] out_data_r;
  logic             out_valid_r;

  logic             pop_s;
  logic             push_s;
  logic             last_push_s;
  logic             set_reg_s;
  logic             sel_mux_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [ROW_W-1:0] head_nxt_s;

  // Circular pointer advance, wrapping at the last FIFO slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Decode the handshake and the array-wide controls from the current state.
  always_comb begin
    pop_s     = out_valid_r & stream.out_ready;
    push_s    = 1'b0;
    set_reg_s = 1'b0;
    sel_mux_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A start request pre-empts accumulation in the same cycle.
        set_reg_s = acc_en & ~start;
        sel_mux_s = 1'b0;
      end
      ST_DRAIN: begin
        // A full FIFO can still take a row if its head leaves this cycle.
        push_s    = (count_r < CNT_W'(FIFO_DEPTH)) | pop_s;
        set_reg_s = push_s;
        sel_mux_s = 1'b1;
      end
      default: begin
        set_reg_s = 1'b0;
        sel_mux_s = 1'b0;
      end
    endcase
    last_push_s = push_s & (row_cnt_r == RCW'(ROWS - 1));
  end

  // Next FIFO occupancy and next head row, so out_data can be a register.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = mem_r[rd_ptr_r];
    if (pop_s) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
    // When the slot being written becomes the head, forward the incoming row.
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = psum_tail;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Row FIFO storage, pointers, occupancy and the registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {ROW_W{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      out_data_r  <= {ROW_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= psum_tail;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      out_data_r  <= head_nxt_s;
      out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
    end
  end

  // Drain sequencer: counts pushed rows and returns to IDLE after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      row_cnt_r <= {RCW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r   <= ST_DRAIN;
            row_cnt_r <= {RCW{1'b0}};
            busy_r    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_push_s) begin
            state_r   <= ST_IDLE;
            row_cnt_r <= {RCW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else if (push_s) begin
            row_cnt_r <= row_cnt_r + RCW'(1);
            done_r    <= 1'b0;
          end else begin
            done_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          row_cnt_r <= {RCW{1'b0}};
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign set_reg          = set_reg_s;
  assign sel_mux          = sel_mux_s;
  assign busy             = busy_r;
  assign done             = done_r;
  assign stream.out_data  = out_data_r;
  assign stream.out_valid = out_valid_r;

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Bench for systolic_drain_ctrl: two instances (row FIFO depth 4 and depth 2)
// share clock, reset and control stimulus. Each drives its own behavioural PE
// column array, and a transaction-level model predicts controls and row order.
module tb_systolic_drain_ctrl;
  localparam int DW   = 8;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int PW   = 2 * DW;
  localparam int RW   = COLS * PW;

  logic clk = 1'b0;
  logic rst_n, acc_en, start, out_ready, load_pulse;
  logic [RW-1:0] tail_w [2];
  logic [RW-1:0] data_w [2];
  logic set_w [2];
  logic sel_w [2];
  logic busy_w [2];
  logic done_w [2];
  logic valid_w [2];
  int n_cmp = 0;
  int n_err = 0;

  systolic_drain_ctrl_if #(.DATA_WIDTH(DW), .COLS(COLS)) if4 ();
  systolic_drain_ctrl_if #(.DATA_WIDTH(DW), .COLS(COLS)) if2 ();

  systolic_drain_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .acc_en(acc_en), .start(start), .psum_tail(tail_w[0]),
    .set_reg(set_w[0]), .sel_mux(sel_w[0]), .busy(busy_w[0]), .done(done_w[0]), .stream(if4));
  systolic_drain_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .acc_en(acc_en), .start(start), .psum_tail(tail_w[1]),
    .set_reg(set_w[1]), .sel_mux(sel_w[1]), .busy(busy_w[1]), .done(done_w[1]), .stream(if2));

  assign if4.out_ready = out_ready;
  assign if2.out_ready = out_ready;
  assign data_w[0]  = if4.out_data;
  assign data_w[1]  = if2.out_data;
  assign valid_w[0] = if4.out_valid;
  assign valid_w[1] = if2.out_valid;

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural PE arrays: each column chain shifts down on set_reg & sel_mux.
  logic [PW-1:0] arr [2][ROWS][COLS];
  logic [PW-1:0] load_vals [ROWS][COLS];
  logic [RW-1:0] exp_rows [ROWS];

  for (genvar g = 0; g < 2; g++) begin : g_tail
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign tail_w[g][c*PW +: PW] = arr[g][ROWS-1][c];
    end
  end

  // Array update: load from the bench, or shift one row toward the tail.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load_pulse) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) arr[i][r][c] <= load_vals[r][c];
      end else if (set_w[i] && sel_w[i]) begin
        for (int c = 0; c < COLS; c++) arr[i][0][c] <= '0;
        for (int r = 1; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) arr[i][r][c] <= arr[i][r-1][c];
      end
    end
  end

  // Reference model: drain flag, rows pushed so far, FIFO occupancy.
  int m_cnt [2];
  int m_pushed [2];
  bit m_drain [2];
  bit m_done [2];

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic bit f_pop(input int i);
    return (m_cnt[i] > 0) && (out_ready === 1'b1);
  endfunction
  function automatic bit f_push(input int i);
    return m_drain[i] && ((m_cnt[i] < depth_of(i)) || f_pop(i));
  endfunction
  function automatic bit f_set(input int i);
    return m_drain[i] ? f_push(i) : ((acc_en === 1'b1) && (start !== 1'b1));
  endfunction

  // Model state advance on each clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= 0; m_pushed[i] <= 0; m_drain[i] <= 1'b0; m_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i]  <= m_cnt[i] + (f_push(i) ? 1 : 0) - (f_pop(i) ? 1 : 0);
        m_done[i] <= f_push(i) && (m_pushed[i] == ROWS - 1);
        if (m_drain[i]) begin
          if (f_push(i)) begin
            m_pushed[i] <= m_pushed[i] + 1;
            if (m_pushed[i] == ROWS - 1) m_drain[i] <= 1'b0;
          end
        end else if (start === 1'b1) begin
          m_drain[i]  <= 1'b1;
          m_pushed[i] <= 0;
        end
      end
    end
  end

  // Observation only: record shifts, done pulses and accepted words.
  logic [RW-1:0] obs0 [$];
  logic [RW-1:0] obs1 [$];
  int shifts [2] = '{0, 0};
  int dones [2] = '{0, 0};
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (set_w[i] && sel_w[i]) shifts[i]++;
        if (done_w[i]) dones[i]++;
      end
      if (valid_w[0] && out_ready) obs0.push_back(data_w[0]);
      if (valid_w[1] && out_ready) obs1.push_back(data_w[1]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Fill both arrays; ramp gives row r the value r+1 in every column.
  task automatic load_array(input bit ramp);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        load_vals[r][c] = ramp ? PW'(r + 1) : PW'($urandom);
    for (int k = 0; k < ROWS; k++)
      for (int c = 0; c < COLS; c++)
        exp_rows[k][c*PW +: PW] = load_vals[ROWS-1-k][c];
    load_pulse = 1'b1;
    tick();
    load_pulse = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({valid_w[i], busy_w[i], done_w[i], set_w[i], sel_w[i]} !== 5'b00000 || data_w[i] !== {RW{1'b0}}) begin
        n_err++;
        $display("FAIL reset_state dut%0d: valid/busy/done/set/sel=%b data=%h, want 00000 data 0",
                 i, {valid_w[i], busy_w[i], done_w[i], set_w[i], sel_w[i]}, data_w[i]);
      end
    end
    acc_en = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (set_w[i] !== 1'b1) begin n_err++; $display("FAIL reset_acc dut%0d: set_reg=%b want 1", i, set_w[i]); end
    end
    acc_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_acc_passthrough();
    bit a;
    for (int n = 0; n < 8; n++) begin
      a = (n < 2) ? (n == 0) : 1'($urandom);
      acc_en = a; #2;
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (set_w[i] !== a || sel_w[i] !== 1'b0) begin
          n_err++; $display("FAIL acc_pass dut%0d: set/sel=%b%b want %b0", i, set_w[i], sel_w[i], a);
        end
      end
      tick();
    end
    acc_en = 1'b0;
  endtask

  task automatic test_free_drain();
    int b0, b1, s0, s1, d0, d1, cyc;
    out_ready = 1'b1;
    load_array(1'b1);
    b0 = obs0.size(); b1 = obs1.size(); s0 = shifts[0]; s1 = shifts[1]; d0 = dones[0]; d1 = dones[1];
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while ((m_drain[0] || m_drain[1] || m_cnt[0] > 0 || m_cnt[1] > 0) && cyc < 40) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({set_w[i], sel_w[i], busy_w[i], done_w[i], valid_w[i]} !== {f_set(i), m_drain[i], m_drain[i], m_done[i], m_cnt[i] > 0}) begin
          n_err++;
          $display("FAIL free_ctrl dut%0d cyc%0d: set/sel/busy/done/valid=%b want %b", i, cyc,
                   {set_w[i], sel_w[i], busy_w[i], done_w[i], valid_w[i]}, {f_set(i), m_drain[i], m_drain[i], m_done[i], m_cnt[i] > 0});
        end
      end
      tick(); cyc++;
    end
    n_cmp++;
    if (cyc >= 40) begin n_err++; $display("FAIL free_timeout: drain not finished in 40 cycles"); end
    n_cmp++;
    if (shifts[0] - s0 != ROWS || shifts[1] - s1 != ROWS || dones[0] - d0 != 1 || dones[1] - d1 != 1) begin
      n_err++;
      $display("FAIL free_counts: shifts=%0d/%0d dones=%0d/%0d want %0d/%0d 1/1",
               shifts[0] - s0, shifts[1] - s1, dones[0] - d0, dones[1] - d1, ROWS, ROWS);
    end
    n_cmp++;
    if (obs0.size() - b0 != ROWS || obs1.size() - b1 != ROWS) begin
      n_err++; $display("FAIL free_words: got %0d/%0d words want %0d", obs0.size() - b0, obs1.size() - b1, ROWS);
    end else begin
      for (int k = 0; k < ROWS; k++) begin
        n_cmp++;
        if (obs0[b0+k] !== exp_rows[k] || obs1[b1+k] !== exp_rows[k]) begin
          n_err++; $display("FAIL free_data word%0d: got %h / %h want %h", k, obs0[b0+k], obs1[b1+k], exp_rows[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int b0, b1, s0, s1, d0, d1, cyc;
    out_ready = 1'b0;
    load_array(1'b0);
    b0 = obs0.size(); b1 = obs1.size(); s0 = shifts[0]; s1 = shifts[1]; d0 = dones[0]; d1 = dones[1];
    start = 1'b1; tick(); start = 1'b0;
    for (cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({set_w[i], sel_w[i], busy_w[i], done_w[i], valid_w[i]} !== {f_set(i), m_drain[i], m_drain[i], m_done[i], m_cnt[i] > 0}) begin
          n_err++;
          $display("FAIL bp_ctrl dut%0d cyc%0d: set/sel/busy/done/valid=%b want %b", i, cyc,
                   {set_w[i], sel_w[i], busy_w[i], done_w[i], valid_w[i]}, {f_set(i), m_drain[i], m_drain[i], m_done[i], m_cnt[i] > 0});
        end
      end
      tick();
    end
    n_cmp++;
    if (shifts[0] - s0 != 4 || dones[0] - d0 != 1 || valid_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      n_err++; $display("FAIL bp_depth4: shifts=%0d dones=%0d valid=%b busy=%b want 4 1 1 0",
                        shifts[0] - s0, dones[0] - d0, valid_w[0], busy_w[0]);
    end
    n_cmp++;
    if (shifts[1] - s1 != 2 || set_w[1] !== 1'b0 || busy_w[1] !== 1'b1 || tail_w[1] !== exp_rows[2]) begin
      n_err++; $display("FAIL bp_stall: shifts=%0d set=%b busy=%b tail=%h want 2 0 1 %h",
                        shifts[1] - s1, set_w[1], busy_w[1], tail_w[1], exp_rows[2]);
    end
    out_ready = 1'b1; #2;
    n_cmp++;
    if (set_w[1] !== 1'b1 || sel_w[1] !== 1'b1 || valid_w[1] !== 1'b1) begin
      n_err++; $display("FAIL bp_pulse: set/sel/valid=%b%b%b want 111", set_w[1], sel_w[1], valid_w[1]);
    end
    tick(); out_ready = 1'b0; #2;
    n_cmp++;
    if (shifts[1] - s1 != 3 || valid_w[1] !== 1'b1 || obs1.size() - b1 != 1 || m_cnt[1] != 2) begin
      n_err++; $display("FAIL bp_swap: shifts=%0d valid=%b popped=%0d want 3 1 1", shifts[1] - s1, valid_w[1], obs1.size() - b1);
    end
    out_ready = 1'b1;
    cyc = 0;
    while ((m_drain[0] || m_drain[1] || m_cnt[0] > 0 || m_cnt[1] > 0) && cyc < 40) begin
      tick(); cyc++;
    end
    n_cmp++;
    if (cyc >= 40) begin n_err++; $display("FAIL bp_timeout: drain not finished in 40 cycles"); end
    #2;
    n_cmp++;
    if (valid_w[0] !== 1'b0 || valid_w[1] !== 1'b0 || dones[1] - d1 != 1) begin
      n_err++; $display("FAIL bp_empty: valid=%b%b dones=%0d want 00 1", valid_w[0], valid_w[1], dones[1] - d1);
    end
    n_cmp++;
    if (obs0.size() - b0 != ROWS || obs1.size() - b1 != ROWS) begin
      n_err++; $display("FAIL bp_words: got %0d/%0d words want %0d", obs0.size() - b0, obs1.size() - b1, ROWS);
    end else begin
      for (int k = 0; k < ROWS; k++) begin
        n_cmp++;
        if (obs0[b0+k] !== exp_rows[k] || obs1[b1+k] !== exp_rows[k]) begin
          n_err++; $display("FAIL bp_data word%0d: got %h / %h want %h", k, obs0[b0+k], obs1[b1+k], exp_rows[k]);
        end
      end
    end
  endtask

  task automatic test_collision_restart();
    int b0, s0, d0, cyc;
    out_ready = 1'b1;
    load_array(1'b0);
    b0 = obs0.size(); s0 = shifts[0]; d0 = dones[0];
    acc_en = 1'b1; start = 1'b1; #2;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (set_w[i] !== 1'b0) begin n_err++; $display("FAIL collide_set dut%0d: set_reg=%b want 0", i, set_w[i]); end
    end
    tick(); start = 1'b0;
    cyc = 0;
    while ((m_drain[0] || m_drain[1] || m_cnt[0] > 0 || m_cnt[1] > 0) && cyc < 40) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if ({set_w[i], sel_w[i], busy_w[i], done_w[i]} !== {f_set(i), m_drain[i], m_drain[i], m_done[i]}) begin
          n_err++;
          $display("FAIL collide_ctrl dut%0d cyc%0d: set/sel/busy/done=%b want %b", i, cyc,
                   {set_w[i], sel_w[i], busy_w[i], done_w[i]}, {f_set(i), m_drain[i], m_drain[i], m_done[i]});
        end
      end
      tick(); cyc++;
      start  = (cyc == 2);
      acc_en = 1'($urandom);
    end
    start = 1'b0; acc_en = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (cyc >= 40 || busy_w[0] !== 1'b0 || shifts[0] - s0 != ROWS || dones[0] - d0 != 1 || obs0.size() - b0 != ROWS) begin
      n_err++; $display("FAIL collide_restart: busy=%b shifts=%0d dones=%0d words=%0d want 0 %0d 1 %0d",
                        busy_w[0], shifts[0] - s0, dones[0] - d0, obs0.size() - b0, ROWS, ROWS);
    end else begin
      for (int k = 0; k < ROWS; k++) begin
        n_cmp++;
        if (obs0[b0+k] !== exp_rows[k]) begin
          n_err++; $display("FAIL collide_data word%0d: got %h want %h", k, obs0[b0+k], exp_rows[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int b1, s1, cyc;
    out_ready = 1'b0;
    load_array(1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst_n = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({valid_w[i], busy_w[i], done_w[i], set_w[i], sel_w[i]} !== 5'b00000) begin
        n_err++; $display("FAIL mid_reset dut%0d: valid/busy/done/set/sel=%b want 00000",
                          i, {valid_w[i], busy_w[i], done_w[i], set_w[i], sel_w[i]});
      end
    end
    acc_en = 1'b1; #1;
    n_cmp++;
    if (set_w[0] !== 1'b1 || set_w[1] !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_acc: set_reg=%b%b want 11", set_w[0], set_w[1]);
    end
    acc_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    load_array(1'b0);
    b1 = obs1.size(); s1 = shifts[1];
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while ((m_drain[0] || m_drain[1] || m_cnt[0] > 0 || m_cnt[1] > 0) && cyc < 40) begin
      tick(); cyc++;
    end
    n_cmp++;
    if (cyc >= 40 || shifts[1] - s1 != ROWS || obs1.size() - b1 != ROWS) begin
      n_err++; $display("FAIL mid_fresh: shifts=%0d words=%0d want %0d", shifts[1] - s1, obs1.size() - b1, ROWS);
    end else begin
      for (int k = 0; k < ROWS; k++) begin
        n_cmp++;
        if (obs1[b1+k] !== exp_rows[k]) begin
          n_err++; $display("FAIL mid_data word%0d: got %h want %h", k, obs1[b1+k], exp_rows[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    int b0, b1, cyc;
    for (int it = 0; it < 4; it++) begin
      out_ready = 1'($urandom);
      load_array(1'b0);
      b0 = obs0.size(); b1 = obs1.size();
      start = 1'b1; tick(); start = 1'b0;
      cyc = 0;
      while ((m_drain[0] || m_drain[1] || m_cnt[0] > 0 || m_cnt[1] > 0) && cyc < 200) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          n_cmp++;
          if ({set_w[i], sel_w[i], busy_w[i], done_w[i], valid_w[i]} !== {f_set(i), m_drain[i], m_drain[i], m_done[i], m_cnt[i] > 0}) begin
            n_err++;
            $display("FAIL rand_ctrl it%0d dut%0d cyc%0d: set/sel/busy/done/valid=%b want %b", it, i, cyc,
                     {set_w[i], sel_w[i], busy_w[i], done_w[i], valid_w[i]}, {f_set(i), m_drain[i], m_drain[i], m_done[i], m_cnt[i] > 0});
          end
        end
        tick(); cyc++;
        out_ready = 1'($urandom);
        acc_en    = 1'($urandom);
      end
      acc_en = 1'b0;
      n_cmp++;
      if (cyc >= 200 || obs0.size() - b0 != ROWS || obs1.size() - b1 != ROWS) begin
        n_err++; $display("FAIL rand_words it%0d: got %0d/%0d words want %0d", it, obs0.size() - b0, obs1.size() - b1, ROWS);
      end else begin
        for (int k = 0; k < ROWS; k++) begin
          n_cmp++;
          if (obs0[b0+k] !== exp_rows[k] || obs1[b1+k] !== exp_rows[k]) begin
            n_err++; $display("FAIL rand_data it%0d word%0d: got %h / %h want %h", it, k, obs0[b0+k], obs1[b1+k], exp_rows[k]);
          end
        end
      end
    end
  endtask

  // Test sequence.
  initial begin
    rst_n = 1'b0; acc_en = 1'b0; start = 1'b0; out_ready = 1'b0; load_pulse = 1'b0;
    test_reset();
    test_acc_passthrough();
    test_free_drain();
    test_backpressure();
    test_collision_restart();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 0);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/systolic_drain_ctrl.md
Name: systolic_drain_ctrl

Overview:
- Downstream collector for the output-stationary PE array.
- After accumulation, it drives the array-wide set_reg/sel_mux controls to shift partial sums down each column's psum chain.
- It captures the value emerging at the chain tail (bottom row psum_out) each shift cycle into a row FIFO and presents it on a valid/ready stream.
- During compute it passes the accumulate enable through to the array.

Parameters:
- DATA_WIDTH, 8, PE operand width; each psum is 2*DATA_WIDTH bits.
- ROWS, 4, PEs per column chain = rows drained per drain operation.
- COLS, 4, number of columns; one psum per column per captured row.
- FIFO_DEPTH, 4, row-FIFO entries (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- acc_en  in  1  accumulate request from compute sequencer; passed to set_reg in IDLE.
- start  in  1  single-cycle pulse: accumulation finished, begin drain.
- psum_tail  in  COLS*2*DATA_WIDTH  bottom-row psum_out of all columns; column c at [c*2*DATA_WIDTH +: 2*DATA_WIDTH].
- set_reg  out  1  array-wide PE register enable.
- sel_mux  out  1  array-wide PE mux select (1 = load psum_in, i.e. shift).
- out_data  out  COLS*2*DATA_WIDTH  FIFO head row, same column packing.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- busy  out  1  high in DRAIN.
- done  out  1  one-cycle pulse after the last row is pushed.

Behaviour:
- Reset: state IDLE, row counter 0, FIFO count 0, FIFO storage cleared, out_valid 0, out_data 0, busy 0, done 0. Reset mid-drain aborts the drain; rows already in the FIFO are lost.
- State IDLE:
  - set_reg = acc_en, sel_mux = 0 (combinational).
  - start=1 moves to DRAIN next cycle, row counter cleared.
  - If start and acc_en are both high, start wins: set_reg = 0 that cycle, so no accumulate occurs.
- State DRAIN:
  - push = (count < FIFO_DEPTH) | (out_valid & out_ready). This is a combinational out_ready -> set_reg path, which is accepted.
  - On a push cycle: psum_tail is written to the FIFO, and set_reg = 1, sel_mux = 1 in the same cycle. The array therefore shifts on the same edge, and the next row appears at psum_tail the next cycle.
  - No push (FIFO full, no pop): set_reg = 0, sel_mux = 1; the array holds and nothing is lost.
  - The row counter increments per push. The push with counter = ROWS-1 is the last: next state IDLE, done = 1 for one cycle (registered).
- Shift with the last push is still asserted. Integration ties the top-row psum_in to 0, so the array holds all zeros after drain.
- start during DRAIN is ignored. acc_en during DRAIN is ignored.
- Row order: the first word is the tail-PE row (array row ROWS-1), the last word is array row 0.
- FIFO:
  - Registered storage with circular read/write pointers wrapping at FIFO_DEPTH; count range 0..FIFO_DEPTH.
  - Simultaneous push and pop when full: both occur, count unchanged.
  - Simultaneous push and pop when empty is impossible; no bypass, so the first word appears the cycle after its push.
  - out_data is the head entry, registered; its value when out_valid = 0 is don't-care after reset.
- Pop drains the FIFO in IDLE as well; out_valid may remain high after done.
- busy = (state == DRAIN), registered.

Test Plan:
- Acc passthrough: IDLE, acc_en = 1 -> set_reg = 1, sel_mux = 0. acc_en = 0 -> set_reg = 0.
- Free-flowing drain (out_ready = 1, psum_tail rows 0x0004, 0x0003, 0x0002, 0x0001 per column on successive shifts):
  - set_reg = sel_mux = 1 for exactly 4 cycles.
  - out_data words are 0x0004... then 0x0001..., in order.
  - done pulses once and busy falls together with the IDLE transition.
- Backpressure (FIFO_DEPTH = 4, ROWS = 4, out_ready = 0): all 4 rows pushed and count = 4, done pulses, nothing shifts after that. Then out_ready = 1 -> 4 words out in order, out_valid falls.
- Full-stall, FIFO_DEPTH = 2 with ROWS = 4 and out_ready = 0:
  - set_reg drops after 2 pushes and psum_tail is held.
  - Pulsing out_ready for 1 cycle gives exactly one push plus one pop in that cycle, with count staying 2.
  - All 4 rows eventually arrive intact.
- Start/acc_en collision and re-start: start and acc_en both high -> set_reg = 0 that cycle and DRAIN is entered. start again mid-drain -> ignored, row count still 4.
- Reset mid-drain after 2 pushes: out_valid = 0, busy = 0, set_reg follows acc_en. A fresh start drains 4 rows normally.
